// File: rtl/shift_reg_ctrl_if.sv
// Command/feedback bus between the shift-register sequencer and its requester/register.
// master = requester side (drives command and register feedback), slave = sequencer.
interface shift_reg_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
);
  logic             start;
  logic [1:0]       cmd;
  logic [CNT_W-1:0] count;
  logic             ser_in;
  logic             rotate;
  logic [WIDTH-1:0] q_fb;
  logic [1:0]       sel;
  logic             sr_in;
  logic             sl_in;
  logic             busy;
  logic             done;

  modport master (
    output start, cmd, count, ser_in, rotate, q_fb,
    input  sel, sr_in, sl_in, busy, done
  );

  modport slave (
    input  start, cmd, count, ser_in, rotate, q_fb,
    output sel, sr_in, sl_in, busy, done
  );
endinterface

// File: rtl/shift_reg_ctrl.sv
// Sequencer for a 4-mode universal shift register: runs one load or N-place
// shift/rotate per start/done handshake and supplies the serial fill bits.
module shift_reg_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic              clk,
  input logic              reset,
  shift_reg_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       dir_r, dir_n;
  logic [1:0]       sel_r, sel_n;
  logic             fill_r, fill_n;
  logic             rot_r, rot_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      dir_r  <= 2'b00;
      sel_r  <= 2'b00;
      fill_r <= 1'b0;
      rot_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      dir_r  <= dir_n;
      sel_r  <= sel_n;
      fill_r <= fill_n;
      rot_r  <= rot_n;
      busy_r <= busy_n;
      done_r <= done_n;
    end
  end

  // Next state; the registered outputs are decoded from the next state so they
  // line up with the state they describe.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dir_n   = dir_r;
    fill_n  = fill_r;
    rot_n   = rot_r;
    sel_n   = 2'b00;
    busy_n  = 1'b0;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          fill_n = bus.ser_in;
          rot_n  = bus.rotate;
          dir_n  = bus.cmd;
          unique case (bus.cmd)
            2'b11: state_n = LOAD;
            2'b01, 2'b10: begin
              if (bus.count != '0) begin
                state_n = SHIFT;
                cnt_n   = bus.count;
              end else begin
                state_n = DONE;
              end
            end
            default: state_n = DONE;
          endcase
        end
      end
      LOAD:  state_n = DONE;
      SHIFT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = DONE;
      end
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    unique case (state_n)
      LOAD: begin
        sel_n  = 2'b11;
        busy_n = 1'b1;
      end
      SHIFT: begin
        sel_n  = dir_n;
        busy_n = 1'b1;
      end
      DONE:    done_n = 1'b1;
      default: sel_n  = 2'b00;
    endcase
  end

  assign bus.sel  = sel_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // Rotate feeds the opposite end of the register back in.
  assign bus.sr_in = rot_r ? bus.q_fb[0]       : fill_r;
  assign bus.sl_in = rot_r ? bus.q_fb[WIDTH-1] : fill_r;

endmodule
